// File: rtl/mig_tree_pipe.sv
// Pipelined evaluator for a complete, runtime-programmable majority-inverter tree.
// Each register stage holds one level of node values; config writes only land while the pipe is empty.
module mig_tree_pipe #(
    parameter int NUM_PI = 4,
    parameter int DEPTH  = 3,
    parameter int SW     = $clog2(NUM_PI + 1),
    parameter int AW     = $clog2(3**DEPTH + (3**DEPTH - 1) / 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PI-1:0] pi,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              po,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [SW:0]       cfg_data,
    output logic              cfg_err
);

    localparam int NLEAF = 3**DEPTH;
    localparam int NNODE = (NLEAF - 1) / 2;
    localparam int ROOT  = NNODE - 1;

    // Index of the first node of a level in the flat node vector (level 1 starts at 0).
    function automatic int lvl_off(input int lvl);
        int o = 0;
        for (int i = 1; i < lvl; i++) o += 3**(DEPTH - i);
        return o;
    endfunction

    logic [SW-1:0]    leaf_sel_q [NLEAF];
    logic [SW-1:0]    leaf_sel_d [NLEAF];
    logic [NLEAF-1:0] leaf_inv_q, leaf_inv_d;
    logic [NNODE-1:0] node_inv_q, node_inv_d;
    logic [NNODE-1:0] node_val_q, node_nxt;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             cfg_err_q, cfg_err_d;

    logic             adv, accept, busy;
    logic [NLEAF-1:0] lit;

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // the whole pipe advances together whenever the output slot is free or being consumed.
    assign out_valid = valid_q[DEPTH-1];
    assign po        = node_val_q[ROOT];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv & ~cfg_we;
    assign accept    = in_valid & in_ready;
    assign busy      = |valid_q;
    assign cfg_err   = cfg_err_q;

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        logic [NUM_PI-1:0] hit;
        for (genvar p = 0; p < NUM_PI; p++) begin : g_pi
            assign hit[p] = pi[p] & (leaf_sel_q[i] == SW'(p));
        end
        // Selects at or above NUM_PI match nothing, giving constant 0 before inversion.
        assign lit[i] = (|hit) ^ leaf_inv_q[i];
    end

    for (genvar j = 1; j <= DEPTH; j++) begin : g_lvl
        localparam int CNT = 3**(DEPTH - j);
        localparam int OFF = lvl_off(j);
        for (genvar k = 0; k < CNT; k++) begin : g_node
            logic [2:0] kid;
            if (j == 1) begin : g_from_leaf
                assign kid = lit[3*k +: 3];
            end else begin : g_from_node
                assign kid = node_val_q[lvl_off(j - 1) + 3*k +: 3];
            end
            assign node_nxt[OFF + k] = ((kid[0] & kid[1]) | (kid[0] & kid[2]) | (kid[1] & kid[2]))
                                       ^ node_inv_q[OFF + k];
        end
    end

    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = accept;
        for (int j = 1; j < DEPTH; j++) valid_d[j] = valid_q[j-1];
    end

    always_comb begin
        leaf_sel_d = leaf_sel_q;
        leaf_inv_d = leaf_inv_q;
        node_inv_d = node_inv_q;
        cfg_err_d  = 1'b0;
        if (cfg_we) begin
            if (busy || (32'(cfg_addr) >= NLEAF + NNODE)) begin
                cfg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < NLEAF; i++) begin
                    if (cfg_addr == AW'(i)) begin
                        leaf_sel_d[i] = cfg_data[SW-1:0];
                        leaf_inv_d[i] = cfg_data[SW];
                    end
                end
                for (int n = 0; n < NNODE; n++) begin
                    if (cfg_addr == AW'(NLEAF + n)) node_inv_d[n] = cfg_data[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            node_val_q <= '0;
            node_inv_q <= '0;
            leaf_inv_q <= '0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < NLEAF; i++) leaf_sel_q[i] <= SW'(NUM_PI);
        end else begin
            if (adv) begin
                valid_q    <= valid_d;
                node_val_q <= node_nxt;
            end
            leaf_sel_q <= leaf_sel_d;
            leaf_inv_q <= leaf_inv_d;
            node_inv_q <= node_inv_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_mig_tree_pipe.sv
// Directed bench for mig_tree_pipe (NUM_PI=4, DEPTH=3): streams vectors through
// several tree programs, stalls, rejected config writes and a mid-stream reset.
module tb_mig_tree_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pi = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       in_ready, po, out_valid, cfg_err;

    mig_tree_pipe #(.NUM_PI(4), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .pi(pi), .in_valid(in_valid), .in_ready(in_ready),
        .po(po), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         mode = 0;   // 0: constant 0, 1: MAJ(pi0,pi1,pi2), 2: its complement
    int         first_acc = -1, first_out = -1, last_out = -1, n_out = 0;
    logic [0:0] exp_q[$];
    logic [3:0] vecs [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model(input logic [3:0] v);
        logic [7:0] tab;
        tab = 8'hE8;   // MAJ over pi[2:0]: true for 3,5,6,7
        case (mode)
            1:       return tab[v[2:0]];
            2:       return ~tab[v[2:0]];
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: pop on each delivered output before pushing the newly accepted vector.
    always @(negedge clk) begin
        logic e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_out observed=po %0b expected=no output", po);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("po", 32'(po), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(pi));
                if (first_acc < 0) first_acc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input int n, input int stall_lo, input int stall_hi);
        int sent = 0;
        int c = 0;
        while (sent < n && c < 100) begin
            pi = vecs[sent];
            in_valid = 1'b1;
            out_ready = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
            #1;
            if (c >= stall_lo && c <= stall_hi) begin
                check("stall_in_ready", 32'(in_ready), 0);
                check("stall_out_valid", 32'(out_valid), 1);
                check("stall_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("stall_po", 32'(po), 32'(exp_q[0]));
            end
            if (in_ready) sent++;
            tick();
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, n);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            tick();
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = 6'(addr);
        cfg_data = 4'(data);
        #1;
        check("cfg_in_ready", 32'(in_ready), 0);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_po", 32'(po), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Default config: every vector evaluates to 0, latency 3, back-to-back output
        for (int i = 0; i < 16; i++) vecs[i] = 4'(i);
        mode = 0;
        first_acc = -1; first_out = -1; n_out = 0;
        send_stream(16, -5, -5);
        drain();
        check("t1_n_out", n_out, 16);
        check("t1_latency", first_out - first_acc, 3);
        check("t1_span", last_out - first_out, 15);

        // Program root = MAJ(pi0,pi1,pi2): node1 forced 1 by leaves 3-5, node10 inverted to 1
        cfg_write(0, 0);
        cfg_write(1, 1);
        cfg_write(2, 2);
        cfg_write(3, 12);
        cfg_write(4, 12);
        cfg_write(5, 12);
        cfg_write(37, 1);
        check("t2_cfg_err", 32'(cfg_err), 0);
        mode = 1;
        send_stream(16, -5, -5);
        drain();

        // Root inverted; leaf 6 uses sel=5 which must read as constant 0
        cfg_write(39, 1);
        cfg_write(6, 5);
        cfg_write(7, 12);
        mode = 2;
        send_stream(16, -5, -5);
        drain();

        // Backpressure: out_ready low for stream cycles 4-7
        vecs[0] = 4'd3; vecs[1] = 4'd4; vecs[2] = 4'd7; vecs[3] = 4'd0;
        vecs[4] = 4'd5; vecs[5] = 4'd2; vecs[6] = 4'd6; vecs[7] = 4'd1;
        n_out = 0;
        send_stream(8, 4, 7);
        drain();
        check("t4_n_out", n_out, 8);

        // Config write while a vector is in flight is rejected
        pi = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_write(39, 0);
        check("busy_cfg_err", 32'(cfg_err), 1);
        tick();
        check("busy_cfg_err_pulse", 32'(cfg_err), 0);
        drain();

        // Out-of-range addresses are rejected while idle
        cfg_write(40, 1);
        check("range40_cfg_err", 32'(cfg_err), 1);
        tick();
        check("range40_pulse", 32'(cfg_err), 0);
        cfg_write(63, 0);
        check("range63_cfg_err", 32'(cfg_err), 1);
        tick();
        n_out = 0;
        send_stream(4, -5, -5);
        drain();
        check("t5_n_out", n_out, 4);

        // Config write and vector in the same idle cycle: write wins, vector follows with new config
        cfg_we = 1'b1;
        cfg_addr = 6'd39;
        cfg_data = 4'd0;
        in_valid = 1'b1;
        pi = 4'b0011;
        #1;
        check("sim_in_ready_low", 32'(in_ready), 0);
        tick();
        cfg_we = 1'b0;
        mode = 1;
        check("sim_cfg_err", 32'(cfg_err), 0);
        #1;
        check("sim_in_ready_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        pi = 4'b0100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // Reset with two vectors in flight
        n_out = 0;
        pi = 4'b0111;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_po", 32'(po), 0);
        exp_q.delete();
        rst = 1'b0;
        mode = 0;
        pi = 4'b0111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
        repeat (4) tick();
        check("midrst_n_out", n_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
